meter_sequencer: RTL and testbench

- Measurement controller for the signal-measurement front end.
- Takes one asynchronous input signal and sequences frequency, period or duty-cycle measurements on a single shared edge/clock counter.
- Auto mode cycles through all three measurement types.
- Presents each result with a mode tag and a valid pulse; the top level latches it into the 8-digit display word.

---
 rtl/meter_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_meter_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/meter_sequencer.sv
// Frequency / period / duty measurement sequencer on one shared edge/clock counter.
// Optional METER_BCD_OUT_EN converts each non-timeout result to packed BCD.
module meter_sequencer #(
   parameter int unsigned GATE_CYCLES    = 100000000,
   parameter int unsigned TIMEOUT_CYCLES = 200000000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic [1:0]       ModeSel,
   input  logic             Sig,
   output logic [CNT_W-1:0] Result,
   output logic [1:0]       ResultMode,
   output logic             ResultValid,
   output logic             Timeout,
   output logic             Busy
);

   localparam int unsigned NW = CNT_W + 10;
   localparam int unsigned DW = $clog2(NW);

   localparam logic [1:0] M_FREQ = 2'd0;
   localparam logic [1:0] M_PER  = 2'd1;
   localparam logic [1:0] M_DUTY = 2'd2;
   localparam logic [1:0] M_AUTO = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_MEAS,
      S_DIV,
`ifdef METER_BCD_OUT_EN
      S_CONV,
`endif
      S_DONE
   } state_t;

`ifdef METER_BCD_OUT_EN
   localparam state_t S_FIN = S_CONV;
`else
   localparam state_t S_FIN = S_DONE;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   logic sync1, sync2, sig_q, rise, fall;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sig_q <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= Sig;
         sync2 <= sync1;
         sig_q <= sync2;
         rise  <= sync2 & ~sig_q;
         fall  <= ~sync2 & sig_q;
      end
   end

   state_t           state;
   logic [1:0]       mode, ptr, nptr, sel_mode;
   logic             auto_r, hi_done, tmo;
   logic [CNT_W-1:0] cnt, gcnt, tmr, hi, den, rem, val;
   logic [NW-1:0]    num;
   logic [DW-1:0]    dcnt;

   logic [CNT_W-1:0] cnt_inc, gcnt_inc, tmr_inc, rem_nxt, quo;
   logic [CNT_W:0]   rem_sh;
   logic             q_bit, tmr_hit, gate_hit, in_meas;

   assign cnt_inc  = sat_inc(cnt);
   assign gcnt_inc = sat_inc(gcnt);
   assign tmr_inc  = sat_inc(tmr);
   assign tmr_hit  = (tmr == CNT_W'(TIMEOUT_CYCLES - 1));
   assign gate_hit = (gcnt == CNT_W'(GATE_CYCLES - 1));

   // restoring divider: one quotient bit per cycle, quotient shifts into num
   assign rem_sh  = {rem, num[NW-1]};
   assign q_bit   = (rem_sh >= {1'b0, den});
   assign rem_nxt = q_bit ? CNT_W'(rem_sh - {1'b0, den}) : rem_sh[CNT_W-1:0];
   assign quo     = {num[CNT_W-2:0], q_bit};

   assign nptr     = !auto_r ? ptr : (ptr == M_DUTY) ? M_FREQ : ptr + 2'd1;
   assign sel_mode = (ModeSel == M_AUTO) ? ptr : ModeSel;

`ifdef METER_BCD_OUT_EN
   localparam int unsigned BW = 4 * ((CNT_W + 2) / 3);

   function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b,
                                              input logic bin);
      logic [BW-1:0] t;
      t = b;
      for (int i = 0; i < int'(BW / 4); i++)
         if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      return {t[BW-2:0], bin};
   endfunction

   logic [BW-1:0] bcd, bcd_nxt;
   assign bcd_nxt = dd_step(bcd, val[CNT_W-1]);
   assign in_meas = state inside {S_ARM, S_MEAS, S_DIV, S_CONV};
`else
   assign in_meas = state inside {S_ARM, S_MEAS, S_DIV};
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= S_IDLE;
         mode        <= M_FREQ;
         ptr         <= M_FREQ;
         auto_r      <= 1'b0;
         hi_done     <= 1'b0;
         tmo         <= 1'b0;
         cnt         <= '0;
         gcnt        <= '0;
         tmr         <= '0;
         hi          <= '0;
         den         <= '0;
         rem         <= '0;
         val         <= '0;
         num         <= '0;
         dcnt        <= '0;
         Result      <= '0;
         ResultMode  <= 2'd0;
         ResultValid <= 1'b0;
         Timeout     <= 1'b0;
         Busy        <= 1'b0;
`ifdef METER_BCD_OUT_EN
         bcd         <= '0;
`endif
      end else begin
         ResultValid <= 1'b0;
`ifdef METER_BCD_OUT_EN
         if (state != S_CONV) bcd <= '0;
         if (state != S_DIV && state != S_CONV) dcnt <= '0;
`else
         if (state != S_DIV) dcnt <= '0;
`endif
         if (!En && in_meas) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (En) begin
                     mode   <= sel_mode;
                     auto_r <= (ModeSel == M_AUTO);
                     tmr    <= '0;
                     state  <= S_ARM;
                     Busy   <= 1'b1;
                  end
               end
               S_ARM: begin
                  cnt     <= '0;
                  gcnt    <= '0;
                  hi_done <= 1'b0;
                  if (mode == M_FREQ) begin
                     state <= S_MEAS;
                  end else if (rise) begin
                     tmr   <= '0;
                     state <= S_MEAS;
                  end else if (tmr_hit) begin
                     val   <= '0;
                     tmo   <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     tmr <= tmr_inc;
                  end
               end
               S_MEAS: begin
                  if (mode == M_FREQ) begin
                     gcnt <= gcnt_inc;
                     if (rise) cnt <= cnt_inc;
                     if (gate_hit) begin
                        val   <= rise ? cnt_inc : cnt;
                        tmo   <= 1'b0;
                        state <= S_FIN;
                     end
                  end else begin
                     cnt <= cnt_inc;
                     tmr <= tmr_inc;
                     if (mode == M_PER && rise) begin
                        val   <= cnt_inc;
                        tmo   <= 1'b0;
                        state <= S_FIN;
                     end else if (mode == M_DUTY && !hi_done && fall) begin
                        hi      <= cnt_inc;
                        hi_done <= 1'b1;
                        tmr     <= '0;
                     end else if (mode == M_DUTY && hi_done && rise) begin
                        num   <= NW'(hi) * NW'(1000);
                        den   <= cnt_inc;
                        rem   <= '0;
                        state <= S_DIV;
                     end else if (tmr_hit) begin
                        val   <= '0;
                        tmo   <= 1'b1;
                        state <= S_DONE;
                     end
                  end
               end
               S_DIV: begin
                  num  <= {num[NW-2:0], q_bit};
                  rem  <= rem_nxt;
                  dcnt <= dcnt + 1'b1;
                  if (dcnt == DW'(NW - 1)) begin
                     val   <= (den == '0) ? '0 : quo;
                     tmo   <= 1'b0;
                     dcnt  <= '0;
                     state <= S_FIN;
                  end
               end
`ifdef METER_BCD_OUT_EN
               S_CONV: begin
                  bcd  <= bcd_nxt;
                  val  <= val << 1;
                  dcnt <= dcnt + 1'b1;
                  if (dcnt == DW'(CNT_W - 1)) begin
                     val   <= (|bcd_nxt[BW-1:32]) ? CNT_W'(32'h9999_9999)
                                                  : CNT_W'(bcd_nxt[31:0]);
                     state <= S_DONE;
                  end
               end
`endif
               S_DONE: begin
                  Result      <= val;
                  ResultMode  <= mode;
                  Timeout     <= tmo;
                  ResultValid <= 1'b1;
                  ptr         <= nptr;
                  mode        <= (ModeSel == M_AUTO) ? nptr : ModeSel;
                  auto_r      <= (ModeSel == M_AUTO);
                  if (En) begin
                     tmr   <= '0;
                     state <= S_ARM;
                  end else begin
                     state <= S_IDLE;
                     Busy  <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_meter_sequencer.sv
// Directed bench for meter_sequencer: table of single-mode runs plus
// hand-written auto, abort and reset-during-divide sequences.
module tb_meter_sequencer;

   localparam int CNT_W = 32;
   localparam int GATE  = 1000;
   localparam int TMO   = 5000;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic             En = 1'b0;
   logic [1:0]       ModeSel = 2'd0;
   logic             Sig = 1'b0;
   logic [CNT_W-1:0] Result;
   logic [1:0]       ResultMode;
   logic             ResultValid;
   logic             Timeout;
   logic             Busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_rise = 0;
   bit sig_run = 1'b0;

   meter_sequencer #(
      .GATE_CYCLES(GATE),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(CNT_W)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .En(En),
      .ModeSel(ModeSel),
      .Sig(Sig),
      .Result(Result),
      .ResultMode(ResultMode),
      .ResultValid(ResultValid),
      .Timeout(Timeout),
      .Busy(Busy)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // 100-cycle period, 25 high; phase restarts whenever the source is enabled
   initial begin : gen
      int ph;
      ph = 0;
      forever begin
         @(posedge Clk);
         #1;
         if (!sig_run) begin
            Sig = 1'b0;
            ph = 0;
         end else begin
            if (ph == 0) last_rise = cyc;
            Sig = (ph < 25);
            ph = (ph + 1) % 100;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic wait_valid(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(posedge Clk);
         #1;
         if (ResultValid) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid: no ResultValid within %0d cycles", maxc);
      end
   endtask

   task automatic wait_rise(output bit ok);
      int r0;
      r0 = last_rise;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step(1);
         if (last_rise != r0) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_rise: no Sig rise within 300 cycles");
      end
   endtask

   task automatic do_reset();
      En = 1'b0;
      sig_run = 1'b0;
      Rst = 1'b1;
      step(2);
      Rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  sel;
      bit          sig;
      logic [31:0] res;
      logic [1:0]  rmode;
      logic        tmo;
      int          maxw;
      int          ival;
   } vec_t;

   vec_t vt[6];

   initial begin
      bit ok;
      int t1, d, dper, dduty, nv;
      logic [1:0] amode[4];
      logic [31:0] ares[4];

      vt[0] = '{2'd0, 1'b1, 32'd10,  2'd0, 1'b0, 2100, 1002};
      vt[1] = '{2'd1, 1'b1, 32'd100, 2'd1, 1'b0, 400,  0};
      vt[2] = '{2'd2, 1'b1, 32'd250, 2'd2, 1'b0, 400,  0};
      vt[3] = '{2'd1, 1'b0, 32'd0,   2'd1, 1'b1, 6000, 0};
      vt[4] = '{2'd0, 1'b0, 32'd0,   2'd0, 1'b0, 2100, 1002};
      vt[5] = '{2'd2, 1'b0, 32'd0,   2'd2, 1'b1, 6000, 0};
      amode = '{2'd0, 2'd1, 2'd2, 2'd0};
      ares  = '{32'd10, 32'd100, 32'd250, 32'd10};
      dper = 0;
      dduty = 0;

      do_reset();
      step(1);
      check("reset Result", Result, 0);
      check("reset ResultMode", ResultMode, 0);
      check("reset ResultValid", ResultValid, 0);
      check("reset Timeout", Timeout, 0);
      check("reset Busy", Busy, 0);

      for (int k = 0; k < 6; k++) begin
         do_reset();
         ModeSel = vt[k].sel;
         sig_run = vt[k].sig;
         step(150);
         En = 1'b1;
         wait_valid(vt[k].maxw, ok);
         if (ok) begin
            t1 = cyc;
            d = cyc - last_rise;
            if (k == 1) dper = d;
            if (k == 2) dduty = d;
            check($sformatf("v%0d result", k), Result, vt[k].res);
            check($sformatf("v%0d mode", k), ResultMode, vt[k].rmode);
            check($sformatf("v%0d timeout", k), Timeout, vt[k].tmo);
            check($sformatf("v%0d busy", k), Busy, 1);
            step(1);
            check($sformatf("v%0d pulse width", k), ResultValid, 0);
            wait_valid(vt[k].maxw, ok);
            if (ok) begin
               check($sformatf("v%0d second result", k), Result, vt[k].res);
               check($sformatf("v%0d second timeout", k), Timeout, vt[k].tmo);
               if (vt[k].ival != 0)
                  check($sformatf("v%0d interval", k), cyc - t1, vt[k].ival);
            end
         end
      end
      check("duty divide latency", dduty - dper, CNT_W + 10);

      // auto-cycle through freq, period, duty and back to freq
      do_reset();
      ModeSel = 2'd3;
      sig_run = 1'b1;
      step(150);
      En = 1'b1;
      for (int j = 0; j < 4; j++) begin
         wait_valid(2100, ok);
         if (ok) begin
            check($sformatf("auto%0d mode", j), ResultMode, amode[j]);
            check($sformatf("auto%0d result", j), Result, ares[j]);
         end
      end

      // drop En in the middle of a frequency gate
      do_reset();
      ModeSel = 2'd0;
      sig_run = 1'b1;
      step(150);
      En = 1'b1;
      wait_valid(2100, ok);
      step(500);
      check("abort busy before", Busy, 1);
      En = 1'b0;
      step(1);
      check("abort busy after", Busy, 0);
      nv = 0;
      for (int i = 0; i < 1500; i++) begin
         step(1);
         if (ResultValid) nv++;
      end
      check("abort no valid", nv, 0);
      check("abort result held", Result, 10);

      // reset while the duty divider is running
      do_reset();
      ModeSel = 2'd2;
      sig_run = 1'b1;
      step(150);
      En = 1'b1;
      wait_valid(400, ok);
      wait_rise(ok);
      wait_rise(ok);
      step(20);
      check("div busy", Busy, 1);
      check("div old result", Result, 250);
      check("div old mode", ResultMode, 2);
      Rst = 1'b1;
      step(1);
      check("rst-div Result", Result, 0);
      check("rst-div ResultMode", ResultMode, 0);
      check("rst-div ResultValid", ResultValid, 0);
      check("rst-div Timeout", Timeout, 0);
      check("rst-div Busy", Busy, 0);
      Rst = 1'b0;
      En = 1'b0;
      sig_run = 1'b0;
      step(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
